// File: rtl/fft_out_serializer_if.sv
// fft_out_serializer_if
//    Bundles the frame-capture side and the bin-stream side of the FFT
//    output serializer.
//    master : producer/consumer view (drives in_*, out_ready)
//    slave  : serializer view (drives in_ready, out_*, overflow)
//    Signals:
//       in_valid/in_ready     frame handshake
//       in_re/in_im           NBINS*DW parallel frame, bin k at [k*DW +: DW]
//       out_valid/out_ready   per-bin beat handshake
//       out_re/out_im         current bin data
//       out_idx/out_last      current bin number / final beat of frame
//       overflow              sticky dropped-frame flag
interface fft_out_serializer_if #(
   parameter int DW    = 16,
   parameter int NBINS = 8,
   parameter int IDX_W = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [NBINS*DW-1:0]   in_re;
   logic [NBINS*DW-1:0]   in_im;
   logic                  out_valid;
   logic                  out_ready;
   logic [DW-1:0]         out_re;
   logic [DW-1:0]         out_im;
   logic [IDX_W-1:0]      out_idx;
   logic                  out_last;
   logic                  overflow;

   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_idx, out_last, overflow
   );

   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_re, out_im, out_idx, out_last, overflow
   );
endinterface

// File: rtl/fft_out_serializer.sv
// fft_out_serializer
//    Captures one parallel 8-bin complex FFT frame per handshake into a
//    two-slot ping-pong buffer and streams it out one bin per beat, in
//    natural bin order. Data passes through bit-exact.
//    Ports:
//       clk    rising-edge clock
//       reset  synchronous active-high reset
//       bus    fft_out_serializer_if.slave (frame in, bin stream out,
//              sticky overflow)
//    Optional build macro FFT_OUT_HALF_SPECTRUM_EN: real-input mode, only
//    bins 0..4 are stored and streamed (bins 5..7 are conjugates).
module fft_out_serializer #(
   parameter int DW    = 16,
   parameter int NBINS = 8,
   parameter int IDX_W = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   fft_out_serializer_if.slave    bus
);

`ifdef FFT_OUT_HALF_SPECTRUM_EN
   localparam int NSTORE = NBINS / 2 + 1;
`else
   localparam int NSTORE = NBINS;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTORE - 1);

   // Buffer occupancy doubles as the control state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic              wr_sel_reg, wr_sel_next;
   logic              rd_sel_reg, rd_sel_next;
   logic              overflow_reg, overflow_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;

   logic [DW-1:0]     slot_re [2][NSTORE];
   logic [DW-1:0]     slot_im [2][NSTORE];
   logic [DW-1:0]     in_re_bin [NSTORE];
   logic [DW-1:0]     in_im_bin [NSTORE];

   logic              in_ready;
   logic              out_valid;
   logic              cap;
   logic              beat;
   logic              last_beat;

   // Unpack the parallel frame into per-bin words (only stored bins).
   for (genvar gi = 0; gi < NSTORE; gi++) begin : g_unpack
      assign in_re_bin[gi] = bus.in_re[gi*DW +: DW];
      assign in_im_bin[gi] = bus.in_im[gi*DW +: DW];
   end

   // in_ready deliberately ignores a same-cycle drain so it is a pure
   // register decode with no path from out_ready.
   assign in_ready  = (state_reg != FULL);
   assign out_valid = (state_reg != EMPTY);
   assign cap       = bus.in_valid && in_ready;
   assign beat      = out_valid && bus.out_ready;
   assign last_beat = beat && (idx_reg == LAST_IDX);

   always_comb begin
      state_next    = state_reg;
      wr_sel_next   = wr_sel_reg ^ cap;
      rd_sel_next   = rd_sel_reg ^ last_beat;
      overflow_next = overflow_reg | (bus.in_valid && !in_ready);
      idx_next      = idx_reg;

      if (beat) begin
         idx_next = last_beat ? '0 : idx_reg + 1'b1;
      end

      // Capture and release in the same cycle leave occupancy unchanged.
      unique case ({cap, last_beat})
         2'b10:   state_next = (state_reg == EMPTY) ? ONE : FULL;
         2'b01:   state_next = (state_reg == FULL) ? ONE : EMPTY;
         default: state_next = state_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= EMPTY;
         wr_sel_reg   <= 1'b0;
         rd_sel_reg   <= 1'b0;
         overflow_reg <= 1'b0;
         idx_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         wr_sel_reg   <= wr_sel_next;
         rd_sel_reg   <= rd_sel_next;
         overflow_reg <= overflow_next;
         idx_reg      <= idx_next;
      end
   end

   // A capture only happens with cnt<2, so slot[wr_sel] never holds
   // unread data when written.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < NSTORE; b++) begin
               slot_re[s][b] <= '0;
               slot_im[s][b] <= '0;
            end
         end
      end else if (cap) begin
         for (int b = 0; b < NSTORE; b++) begin
            slot_re[wr_sel_reg][b] <= in_re_bin[b];
            slot_im[wr_sel_reg][b] <= in_im_bin[b];
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_re    = slot_re[rd_sel_reg][idx_reg];
   assign bus.out_im    = slot_im[rd_sel_reg][idx_reg];
   assign bus.out_idx   = idx_reg;
   assign bus.out_last  = out_valid && (idx_reg == LAST_IDX);
   assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer
//    Directed bench for fft_out_serializer: a vector table for single-frame
//    streaming (free-running and stalled consumer) plus hand-written
//    sequences for overflow, back-to-back frames, simultaneous capture and
//    release, and mid-stream reset.
module tb_fft_out_serializer;

`ifdef FFT_OUT_HALF_SPECTRUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 8;
`endif
   localparam int LAST = NB - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   fft_out_serializer_if #(.DW(16), .NBINS(8), .IDX_W(3)) bus ();

   fft_out_serializer #(.DW(16), .NBINS(8), .IDX_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        in_valid;
      logic        out_ready;
      logic        exp_valid;
      int          exp_idx;
      logic        exp_last;
      logic [15:0] exp_re;
      logic [15:0] exp_im;
   } vec_t;

   vec_t tbl[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic set_frame(input logic [15:0] rb, input logic [15:0] ib);
      for (int k = 0; k < 8; k++) begin
         bus.in_re[k*16 +: 16] = rb + 16'(k);
         bus.in_im[k*16 +: 16] = ib + 16'(k);
      end
   endtask

   task automatic chk_beat(input string tag, input int k, input logic [15:0] rb, input logic [15:0] ib);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_idx"},   32'(bus.out_idx), 32'(k));
      chk({tag, "_re"},    32'(bus.out_re), 32'(16'(rb + 16'(k))));
      chk({tag, "_im"},    32'(bus.out_im), 32'(16'(ib + 16'(k))));
      chk({tag, "_last"},  32'(bus.out_last), 32'(k == LAST));
      $display("beat %s idx=%0d re=%h im=%h last=%0b", tag, bus.out_idx, bus.out_re, bus.out_im, bus.out_last);
   endtask

   task automatic vec_push(input logic iv, input logic rdy, input logic ev, input int k);
      vec_t v;
      v.in_valid  = iv;
      v.out_ready = rdy;
      v.exp_valid = ev;
      v.exp_idx   = ev ? k : 0;
      v.exp_last  = ev && (k == LAST);
      v.exp_re    = ev ? 16'h0100 + 16'(k) : 16'h0;
      v.exp_im    = ev ? 16'h0200 + 16'(k) : 16'h0;
      tbl.push_back(v);
   endtask

   initial begin
      int k;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_re     = '0;
      bus.in_im     = '0;

      // ---------------- reset state
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
      chk("rst_overflow",  32'(bus.overflow), 32'd0);
      chk("rst_out_idx",   32'(bus.out_idx), 32'd0);
      chk("rst_out_last",  32'(bus.out_last), 32'd0);
      chk("rst_out_re",    32'(bus.out_re), 32'd0);
      $display("reset: out_valid=%0b in_ready=%0b overflow=%0b", bus.out_valid, bus.in_ready, bus.overflow);

      // ---------------- vector table: free-running then stalled consumer
      vec_push(1'b1, 1'b1, 1'b0, 0);
      for (int i = 0; i < NB; i++) vec_push(1'b0, 1'b1, 1'b1, i);
      vec_push(1'b0, 1'b1, 1'b0, 0);
      vec_push(1'b1, 1'b1, 1'b0, 0);
      k = 0;
      for (int j = 0; k < NB; j++) begin
         logic rdy;
         rdy = ((j % 3) == 0);
         vec_push(1'b0, rdy, 1'b1, k);
         if (rdy) k++;
      end
      vec_push(1'b0, 1'b1, 1'b0, 0);

      set_frame(16'h0100, 16'h0200);
      foreach (tbl[i]) begin
         bus.in_valid  = tbl[i].in_valid;
         bus.out_ready = tbl[i].out_ready;
         chk("vec_valid", 32'(bus.out_valid), 32'(tbl[i].exp_valid));
         chk("vec_last",  32'(bus.out_last), 32'(tbl[i].exp_last));
         if (tbl[i].exp_valid) begin
            chk("vec_idx", 32'(bus.out_idx), 32'(tbl[i].exp_idx));
            chk("vec_re",  32'(bus.out_re), 32'(tbl[i].exp_re));
            chk("vec_im",  32'(bus.out_im), 32'(tbl[i].exp_im));
         end
         $display("vec %0d: in_valid=%0b out_ready=%0b out_valid=%0b idx=%0d re=%h im=%h last=%0b",
                  i, tbl[i].in_valid, tbl[i].out_ready, bus.out_valid, bus.out_idx,
                  bus.out_re, bus.out_im, bus.out_last);
         tick();
      end
      bus.in_valid = 1'b0;

      // ---------------- A, B, C back-to-back with a stalled consumer
      bus.out_ready = 1'b0;
      set_frame(16'h0100, 16'h0200);
      bus.in_valid = 1'b1;
      chk("ovf_a_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      set_frame(16'h1100, 16'h2200);
      chk("ovf_b_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      set_frame(16'h3300, 16'h4400);
      chk("ovf_c_in_ready", 32'(bus.in_ready), 32'd0);
      chk("ovf_pre", 32'(bus.overflow), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      chk("ovf_set", 32'(bus.overflow), 32'd1);
      $display("overflow: frame C offered with in_ready=0, overflow=%0b", bus.overflow);
      bus.out_ready = 1'b1;
      for (int i = 0; i < NB; i++) begin chk_beat("ovfA", i, 16'h0100, 16'h0200); tick(); end
      for (int i = 0; i < NB; i++) begin chk_beat("ovfB", i, 16'h1100, 16'h2200); tick(); end
      chk("ovf_drained", 32'(bus.out_valid), 32'd0);
      chk("ovf_sticky",  32'(bus.overflow), 32'd1);

      // ---------------- D after A's last beat, E on D's last beat
      bus.out_ready = 1'b0;
      set_frame(16'h0100, 16'h0200);
      bus.in_valid = 1'b1;
      tick();
      set_frame(16'h1100, 16'h2200);
      tick();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NB; i++) begin chk_beat("bbA", i, 16'h0100, 16'h0200); tick(); end
      set_frame(16'h8000, 16'hF000);
      bus.in_valid = 1'b1;
      chk("bb_d_in_ready", 32'(bus.in_ready), 32'd1);
      chk_beat("bbB", 0, 16'h1100, 16'h2200);
      tick();
      bus.in_valid = 1'b0;
      chk("bb_full_in_ready", 32'(bus.in_ready), 32'd0);
      for (int i = 1; i < NB; i++) begin chk_beat("bbB", i, 16'h1100, 16'h2200); tick(); end
      for (int i = 0; i < NB; i++) begin
         chk_beat("bbD", i, 16'h8000, 16'hF000);
         if (i == LAST) begin
            set_frame(16'h5500, 16'h6600);
            bus.in_valid = 1'b1;
            chk("bb_e_in_ready", 32'(bus.in_ready), 32'd1);
         end
         tick();
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin chk_beat("bbE", i, 16'h5500, 16'h6600); tick(); end
      chk("bb_drained", 32'(bus.out_valid), 32'd0);

      // ---------------- reset mid-stream, in_valid ignored during reset
      set_frame(16'h0100, 16'h0200);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin chk_beat("preRst", i, 16'h0100, 16'h0200); tick(); end
      reset = 1'b1;
      set_frame(16'h7700, 16'h7800);
      bus.in_valid = 1'b1;
      tick();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mrst_in_ready",  32'(bus.in_ready), 32'd1);
      chk("mrst_overflow",  32'(bus.overflow), 32'd0);
      chk("mrst_out_idx",   32'(bus.out_idx), 32'd0);
      chk("mrst_out_re",    32'(bus.out_re), 32'd0);
      $display("mid-stream reset: out_valid=%0b in_ready=%0b overflow=%0b", bus.out_valid, bus.in_ready, bus.overflow);
      tick();
      chk("mrst_ignored", 32'(bus.out_valid), 32'd0);
      set_frame(16'h1100, 16'h2200);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin chk_beat("postRst", i, 16'h1100, 16'h2200); tick(); end
      chk("post_drained", 32'(bus.out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
- Final stage after the radix-2 stage-3 butterfly.
- Captures one parallel 8-bin complex FFT frame (X0..X7, 16 bits per component) in a single cycle.
- Streams the frame out one bin per beat over a valid/ready interface, in natural bin order.
- Two-frame ping-pong buffer absorbs back-to-back butterfly frames while the consumer stalls.

Parameters:
- DW, 16, width of each real/imag component
- NBINS, 8, bins per frame (fixed for the 8-point FFT; only 8 is supported)
- IDX_W, 3, width of out_idx

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  frame on in_re/in_im is valid this cycle
- in_ready  output  1  buffer can accept a frame
- in_re  input  NBINS*DW  real parts; bin k at [k*DW +: DW]
- in_im  input  NBINS*DW  imag parts; bin k at [k*DW +: DW]
- out_valid  output  1  out_* carry a valid bin
- out_ready  input  1  consumer accepts the beat
- out_re  output  DW  real part of current bin
- out_im  output  DW  imag part of current bin
- out_idx  output  IDX_W  bin number of current beat
- out_last  output  1  high on the final beat of a frame
- overflow  output  1  sticky: a frame was offered while in_ready=0

Behaviour:
- One clock domain (clk); synchronous active-high reset (reset).
- Storage: two frame slots (slot0, slot1) of NBINS complex registers, plus:
  - wr_sel: 1-bit write pointer
  - rd_sel: 1-bit read pointer
  - cnt: 0..2, number of frames held
  - idx: read index, 0..NBINS-1
- State is encoded by cnt:
  - EMPTY (0), ONE (1), FULL (2)
  - in_ready = (cnt != 2), combinational from registers; it does not look ahead to a same-cycle drain.
  - out_valid = (cnt != 0).
- Capture: in_valid && in_ready at an edge writes the whole frame into slot[wr_sel], toggles wr_sel, and increments cnt.
- Read path:
  - out_re/out_im = slot[rd_sel] bin idx.
  - out_idx = idx.
  - out_last = out_valid && (idx == last index).
  - Latency: a frame captured at edge N drives out_valid=1 with bin 0 from edge N onward, i.e. the next cycle.
- Beat transfer: out_valid && out_ready.
  - Not last beat: idx increments.
  - Last beat: idx returns to 0, rd_sel toggles, cnt decrements.
- Simultaneous capture and last-beat drain: cnt is unchanged; both pointers toggle.
- Data stability: while out_valid=1 and out_ready=0, out_re, out_im, out_idx and out_last stay constant. Writes never touch slot[rd_sel] while it holds unread data.
- Overflow:
  - in_valid && !in_ready drops the frame and sets overflow=1.
  - overflow is cleared only by reset.
  - Slot contents and pointers are unaffected.
- Arithmetic: none. Data passes through bit-exact, with no sign extension or rounding.
- Reset, including mid-stream, clears on the next edge:
  - cnt=0, idx=0, wr_sel=0, rd_sel=0, overflow=0
  - This forces out_valid=0, out_last=0, out_idx=0 and in_ready=1.
  - Slot contents are don't-care but are also cleared to 0, so out_re=out_im=0 after reset.
  - Any partially streamed frame is discarded.
  - in_valid during the reset cycle is ignored.

Optional Feature:
- Macro: FFT_OUT_HALF_SPECTRUM_EN.
- Defined:
  - Input is real, so bins 5..7 are conjugates of 3..1.
  - Only bins 0..4 are streamed (5 beats per frame); out_last is asserted at idx==4, then the frame is released.
  - Bins 5..7 are not stored; their storage is omitted.
- Undefined: all 8 bins are streamed and out_last is asserted at idx==7.

Test Plan:
- Single frame; bin k re=0x0100+k, im=0x0200+k; out_ready=1 → one cycle after capture, 8 consecutive beats with out_idx 0..7 and matching data; out_last only on the idx=7 beat; then out_valid=0.
- Same frame; out_ready toggled 1,0,0,1,... → no beat skipped or duplicated; outputs held constant during stalls; 8 beats in total.
- Three frames A, B, C on consecutive cycles with out_ready=0:
  - A and B are accepted; in_ready=0 on C's cycle.
  - C is dropped and overflow=1.
  - After releasing out_ready: 16 beats, A then B; overflow stays 1.
- cnt=2, out_ready=1, new frame D offered on the cycle after the last beat of A → D is accepted; stream is B then D with no gap between frames.
- reset asserted one cycle after the idx=3 beat → next cycle out_valid=0, in_ready=1, overflow=0; a new frame then streams from idx 0.
- With FFT_OUT_HALF_SPECTRUM_EN: ramp frame → 5 beats, idx 0..4, out_last at idx=4; back-to-back frames alternate without gaps.
